// File: rtl/adc_capture_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adc_capture_buf
// Brief    : AD9226 capture stage. Registers the ADC word, forwards the clock,
//            decimates, triggers on level/edge or force, fills a DEPTH-sample
//            buffer and plays it back one word per read request.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module adc_capture_buf #(
  parameter int DATA_W  = 12,
  parameter int DEPTH   = 1024,   // power of two
  parameter int ADDR_W  = 10,     // log2(DEPTH)
  parameter int DECIM_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  date_in,
  output logic               clk_out,
  output logic [DATA_W-1:0]  date_out,
  input  logic               arm,
  input  logic               force_trig,
  input  logic [DATA_W-1:0]  trig_level,
  input  logic               trig_falling,
  input  logic [DECIM_W-1:0] decim,
  input  logic               rd_req,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               busy,
  output logic               done,
  output logic               ovr
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Terminal address: the DEPTH-th write/read lands here.
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

  state_t               r_state;
  state_t               w_state_nxt;

  logic [DECIM_W-1:0]   r_dcnt;
  logic [DECIM_W-1:0]   r_decim;     // ratio in force for the current period
  logic [DATA_W-1:0]    r_prev;
  logic                 r_prev_valid;
  logic [ADDR_W-1:0]    r_wptr;
  logic [ADDR_W-1:0]    r_rptr;
  logic                 r_ovr;
  logic                 r_rd_valid;
  logic [DATA_W-1:0]    r_rd_data;
  logic [DATA_W-1:0]    r_mem [DEPTH];

  logic                 w_kept;
  logic                 w_over_range;
  logic                 w_rise_hit;
  logic                 w_fall_hit;
  logic                 w_level_trig;
  logic                 w_restart;
  logic                 w_we;
  logic                 w_wr_last;
  logic                 w_rd_en;
  logic                 w_track;
  logic [ADDR_W-1:0]    w_waddr;

  assign clk_out  = clk;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign ovr      = r_ovr;
  assign busy     = (r_state == S_ARMED) || (r_state == S_CAPTURE);
  assign done     = (r_state == S_DONE);

  // Everything downstream works on the registered sample date_out.
  assign w_kept       = (r_dcnt == '0);
  assign w_over_range = (date_out == '0) || (&date_out);
  assign w_rise_hit   = r_prev_valid && (r_prev <  trig_level) && (date_out >= trig_level);
  assign w_fall_hit   = r_prev_valid && (r_prev >= trig_level) && (date_out <  trig_level);
  assign w_level_trig = w_kept && (trig_falling ? w_fall_hit : w_rise_hit);

  // The trigger sample always goes to address 0; capture uses the write pointer.
  assign w_waddr = (r_state == S_CAPTURE) ? r_wptr : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and datapath strobes; arm has priority where it is honoured.
  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_we        = 1'b0;
    w_wr_last   = 1'b0;
    w_rd_en     = 1'b0;
    w_track     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (arm) begin
          w_restart   = 1'b1;
          w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (arm) begin
          w_restart   = 1'b1;
          w_state_nxt = S_ARMED;
        end else begin
          w_track = w_kept;
          if (force_trig || w_level_trig) begin
            w_we        = 1'b1;
            w_state_nxt = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        if (w_kept) begin
          w_we = 1'b1;
          if (r_wptr == c_last_addr) begin
            w_wr_last   = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (arm) begin
          w_restart   = 1'b1;
          w_state_nxt = S_ARMED;
        end else if (rd_req) begin
          w_rd_en = 1'b1;
          if (r_rptr == c_last_addr) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Input register, decimation counter, trigger history, pointers and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      date_out     <= '0;
      r_dcnt       <= '0;
      r_decim      <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_ovr        <= 1'b0;
      r_rd_valid   <= 1'b0;
    end else begin
      date_out   <= date_in;
      r_rd_valid <= w_rd_en;

      // A new decim value is only picked up at a wrap (or a restart).
      if (w_restart || (r_dcnt == r_decim)) begin
        r_dcnt  <= '0;
        r_decim <= decim;
      end else begin
        r_dcnt <= r_dcnt + DECIM_W'(1);
      end

      if (w_restart) begin
        r_ovr <= 1'b0;
      end else if (busy && w_kept && w_over_range) begin
        r_ovr <= 1'b1;
      end

      if (w_restart) begin
        r_prev_valid <= 1'b0;
      end else if (w_track) begin
        r_prev       <= date_out;
        r_prev_valid <= 1'b1;
      end

      if (w_restart) begin
        r_wptr <= '0;
      end else if (w_we) begin
        r_wptr <= w_waddr + ADDR_W'(1);
      end

      if (w_restart || w_wr_last) begin
        r_rptr <= '0;
      end else if (w_rd_en) begin
        r_rptr <= r_rptr + ADDR_W'(1);
      end
    end
  end

  // Buffer write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= date_out;
    end
  end

  // Buffer read port with registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (w_rd_en) begin
      r_rd_data <= r_mem[r_rptr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_adc_capture_buf
// Brief    : Directed self-checking bench for adc_capture_buf (DEPTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_capture_buf;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] date_in;
  logic          clk_out;
  logic [DW-1:0] date_out;
  logic          arm;
  logic          force_trig;
  logic [DW-1:0] trig_level;
  logic          trig_falling;
  logic [7:0]    decim;
  logic          rd_req;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic          done;
  logic          ovr;

  logic          ramp_en;
  logic [DW-1:0] ramp_step;
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  adc_capture_buf #(
    .DATA_W (12),
    .DEPTH  (16),
    .ADDR_W (4),
    .DECIM_W(8)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .date_in     (date_in),
    .clk_out     (clk_out),
    .date_out    (date_out),
    .arm         (arm),
    .force_trig  (force_trig),
    .trig_level  (trig_level),
    .trig_falling(trig_falling),
    .decim       (decim),
    .rd_req      (rd_req),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy),
    .done        (done),
    .ovr         (ovr)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ramp_en) date_in = date_in + ramp_step;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int k;
    k = 0;
    while (done !== 1'b1 && k < lim) begin
      tick();
      k++;
    end
    check_val(tag, done, 1);
  endtask

  // Back-to-back reads of words first..first+cnt-1, expected base + i*step.
  task automatic read_run(input string tag, input int first, input int cnt,
                          input logic [DW-1:0] base, input logic [DW-1:0] step);
    logic [DW-1:0] e;
    rd_req = 1'b1;
    for (int i = first; i < first + cnt; i++) begin
      tick();
      e = base + 12'(i) * step;
      check_val(tag, {rd_valid, rd_data}, {1'b1, e});
    end
    rd_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; date_in = '0; arm = 1'b0; force_trig = 1'b0;
    trig_level = '0; trig_falling = 1'b0; decim = '0; rd_req = 1'b0;
    ramp_en = 1'b0; ramp_step = 12'd1;

    // 1. reset and pass-through
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rst_outs", {date_out, rd_data, rd_valid, busy, done, ovr}, 0);
    end
    check_val("clk_out", clk_out, 1);
    rst = 1'b0; date_in = 12'h5A5;
    tick();
    check_val("passthru", date_out, 12'h5A5);

    // 2. rising trigger, decim=0; first kept sample above level must not fire
    trig_level = 12'h800; trig_falling = 1'b0; decim = 8'd0;
    date_in = 12'h900; arm = 1'b1;
    tick();
    arm = 1'b0;
    check_val("t2_busy", busy, 1);
    repeat (20) tick();
    check_val("t2_no_first_trig", {busy, done}, 2'b10);
    date_in = 12'h7F0; ramp_en = 1'b1;
    wait_done("t2_done", 100);
    ramp_en = 1'b0;
    check_val("t2_not_busy", busy, 0);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check_val("t2_rd0", {rd_valid, rd_data}, {1'b1, 12'h800});
    tick();
    check_val("t2_valid_pulse", rd_valid, 0);
    read_run("t2_rd", 1, 15, 12'h800, 12'd1);
    check_val("t2_idle", {busy, done, ovr}, 0);
    tick();
    check_val("t2_valid_end", rd_valid, 0);

    // 3. falling trigger with decim=3 on a descending ramp
    decim = 8'd3; trig_falling = 1'b1; trig_level = 12'h400;
    date_in = 12'h410; ramp_step = 12'hFFF; ramp_en = 1'b1; arm = 1'b1;
    tick();
    arm = 1'b0;
    wait_done("t3_done", 200);
    ramp_en = 1'b0;
    read_run("t3_rd", 0, 16, 12'h3FC, 12'hFFC);
    check_val("t3_ovr", ovr, 0);

    // 4. force_trig on full-scale sample, sticky ovr
    decim = 8'd0; date_in = 12'h100; arm = 1'b1;
    tick();
    arm = 1'b0;
    date_in = 12'hFFF;
    tick();
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0; date_in = 12'h123;
    check_val("t4_ovr_set", {busy, ovr}, 2'b11);
    wait_done("t4_done", 50);
    read_run("t4_rd_fff", 0, 2, 12'hFFF, 12'd0);
    read_run("t4_rd", 2, 14, 12'h123, 12'd0);
    check_val("t4_ovr_hold", ovr, 1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check_val("t4_ovr_clr", {busy, ovr}, 2'b10);

    // 5a. arm and force_trig during CAPTURE are ignored
    trig_falling = 1'b0; trig_level = 12'h800;
    date_in = 12'h200; ramp_step = 12'd1; ramp_en = 1'b1;
    tick();
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    repeat (3) tick();
    arm = 1'b1; force_trig = 1'b1;
    tick();
    arm = 1'b0; force_trig = 1'b0;
    check_val("t5_busy", busy, 1);
    wait_done("t5_done", 40);
    ramp_en = 1'b0;
    read_run("t5_rd", 0, 16, 12'h200, 12'd1);
    check_val("t5_idle", done, 0);

    // 5c. rd_req in IDLE
    rd_req = 1'b1;
    tick();
    check_val("t5_idle_rd", rd_valid, 0);
    rd_req = 1'b0;

    // 5b. arm with rd_req in DONE
    date_in = 12'h300; arm = 1'b1;
    tick();
    arm = 1'b0; force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    wait_done("t5b_done", 40);
    arm = 1'b1; rd_req = 1'b1;
    tick();
    arm = 1'b0; rd_req = 1'b0;
    check_val("t5b_novalid", rd_valid, 0);
    check_val("t5b_armed", {busy, done}, 2'b10);

    // 6a. reset in CAPTURE after 5 writes
    date_in = 12'h000;
    tick();
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    repeat (4) tick();
    check_val("t6_pre", {busy, ovr}, 2'b11);
    rst = 1'b1;
    tick();
    check_val("t6a_rst", {busy, done, rd_valid, ovr}, 0);
    rst = 1'b0;
    tick();
    check_val("t6a_idle", {busy, done}, 0);

    // 6b. reset in DONE after 3 reads, rd_req held high
    arm = 1'b1;
    tick();
    arm = 1'b0; force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    wait_done("t6b_done", 40);
    rd_req = 1'b1;
    repeat (3) tick();
    check_val("t6b_rd", {rd_valid, ovr}, 2'b11);
    rst = 1'b1;
    tick();
    check_val("t6b_rst", {busy, done, rd_valid, ovr, rd_data}, 0);
    rst = 1'b0;
    tick();
    check_val("t6b_idle", {busy, done, rd_valid}, 0);
    rd_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_capture_buf.md
Name: adc_capture_buf

Overview:
- Parametrised successor to the team's single-register ADC capture stage for the AD9226 front end.
- Registers the parallel ADC word and forwards the clock, as before. Adds:
  - programmable decimation;
  - a level/edge trigger with arm/force controls;
  - a DEPTH-sample capture buffer, read out by a one-word-per-request handshake for the UART path.

Parameters:
- DATA_W, 12: ADC sample width.
- DEPTH, 1024: capture buffer depth in samples; must be a power of two.
- ADDR_W, 10: buffer address width; must equal log2(DEPTH).
- DECIM_W, 8: width of the decimation ratio input.

Ports:
- clk  in  1  ADC/system clock.
- rst  in  1  Synchronous, active-high reset.
- date_in  in  DATA_W  Raw ADC sample, offset binary.
- clk_out  out  1  clk forwarded to the ADC; combinational.
- date_out  out  DATA_W  Registered sample; live pass-through.
- arm  in  1  One-cycle pulse: start a new capture.
- force_trig  in  1  One-cycle pulse: trigger immediately while armed.
- trig_level  in  DATA_W  Trigger threshold, unsigned.
- trig_falling  in  1  Edge select: 0 = rising, 1 = falling.
- decim  in  DECIM_W  Keep 1 of every (decim+1) samples.
- rd_req  in  1  Request the next buffered word.
- rd_data  out  DATA_W  Buffer read data.
- rd_valid  out  1  rd_data valid; one-cycle pulse.
- busy  out  1  High in ARMED and CAPTURE.
- done  out  1  High in DONE; the buffer holds unread data.
- ovr  out  1  Sticky over-range flag.

Behaviour:
- Reset values (rst high at a clk edge):
  - state = IDLE; all pointers and the decimation counter = 0.
  - date_out, rd_data, rd_valid, busy, done and ovr all = 0.
  - prev_valid = 0.
  - rst overrides every other input, including mid-capture and mid-readout.
  - Buffer contents are not cleared.
- Input stage:
  - date_out <= date_in every clk; latency 1.
  - All downstream logic uses date_out.
- Decimation:
  - dcnt counts 0..decim, then wraps to 0. It is cleared on arm.
  - A sample is "kept" in the cycle dcnt==0. With decim=0 every sample is kept.
  - A change of decim takes effect at the next wrap.
- ovr: set when a kept sample equals all-zeros or all-ones in ARMED or CAPTURE. Cleared only by arm or rst.
- State machine:
  - IDLE:
    - arm -> ARMED.
  - ARMED:
    - On each kept sample s: prev <= s and prev_valid <= 1.
    - Rising trigger: prev_valid && prev < trig_level && s >= trig_level.
    - Falling trigger: prev_valid && prev >= trig_level && s < trig_level.
    - On a trigger: write s to mem[0], set wptr = 1, -> CAPTURE.
    - force_trig in ARMED behaves as a trigger on the current cycle. The sample written is the current date_out, regardless of dcnt.
    - The first kept sample after arm can never trigger on level, because prev_valid = 0.
  - CAPTURE:
    - Each kept sample: mem[wptr] <= s; wptr++.
    - When the DEPTH-th sample is written -> DONE and rptr = 0.
    - arm and force_trig are ignored.
  - DONE:
    - rd_req -> next cycle: rd_data = mem[rptr], rd_valid = 1; rptr++.
    - After the DEPTH-th read -> IDLE.
    - rd_req is ignored in every state except DONE; rd_valid stays 0.
    - Back-to-back rd_req is legal: one word per cycle.
  - arm in IDLE, ARMED or DONE:
    - Restarts the capture: -> ARMED, clears ovr, dcnt, prev_valid and pointers.
    - Any unread data is discarded.
    - If arm and rd_req arrive in the same DONE cycle, arm wins and no rd_valid is produced.
- Buffer:
  - Single-port-write / single-port-read synchronous RAM, inferable as block RAM.
  - Pointers are ADDR_W bits; wptr reaching DEPTH is detected by a terminal count, not by wrap.
- Outputs are registered except clk_out. busy and done are decoded from the state register.

Test Plan:
1. Reset and pass-through:
   - Stimulus: assert rst for 3 clk, then drive date_in = 12'h5A5.
   - Required: all outputs 0 during reset; date_out = 12'h5A5 one clk after the input.
2. Rising trigger, decim=0, DEPTH=16:
   - Stimulus: trig_level = 12'h800, trig_falling = 0, ramp date_in from 12'h7F0 in steps of +1, pulse arm.
   - Required:
     - No trigger on the first kept sample.
     - Trigger on 12'h800.
     - done after 16 samples.
     - 16 rd_req return 12'h800..12'h80F with rd_valid one clk after each request.
     - Then state = IDLE and done = 0.
3. Falling trigger with decimation:
   - Stimulus: decim = 3, trig_falling = 1, trig_level = 12'h400, descending ramp of -1 per clk from 12'h410.
   - Required: the stored words step by -4; the first stored word is < 12'h400.
4. force_trig and over-range:
   - Stimulus: arm, then force_trig with date_in = 12'hFFF.
   - Required:
     - mem[0] = 12'hFFF and ovr = 1.
     - ovr stays set through readout.
     - ovr clears on the next arm.
5. Control collisions:
   - Stimulus 1: arm and force_trig during CAPTURE.
   - Required 1: both ignored; capture completes normally.
   - Stimulus 2: arm together with rd_req in DONE.
   - Required 2: no rd_valid; state = ARMED.
   - Stimulus 3: rd_req in IDLE.
   - Required 3: no rd_valid.
6. Reset mid-operation:
   - Stimulus: assert rst in CAPTURE after 5 writes, and separately in DONE after 3 reads.
   - Required: next state is IDLE; busy = done = rd_valid = ovr = 0.
